// File: rtl/fp_div_prep.sv
// fp_div_prep -- operand preparation ahead of the Newton-Raphson divider core.
//
// Two-stage valid/ready pipeline. Stage 1 classifies both IEEE-754 single
// operands (NaN / Inf / Zero, subnormals treated as zero). Stage 2 resolves
// special quotients and rescales the divisor mantissa into [0.5,1) by forcing
// its exponent to 126.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_a dividend, in_b divisor
//   out_valid/out_ready result handshake toward the divider
//   out_a               dividend, subnormals flushed to signed zero
//   out_d               divisor with exponent forced to 126
//   out_exp_b           original biased divisor exponent
//   out_sign            quotient sign
//   out_special         quotient fully determined, bypass the divider
//   out_special_val     that quotient (zero when out_special=0)
//   special_cnt         saturating count of delivered special results
//   flush               synchronous clear of both stages
module fp_div_prep #(
  parameter int unsigned CNT_W = 16,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_d,
  output logic [7:0]       out_exp_b,
  output logic             out_sign,
  output logic             out_special,
  output logic [31:0]      out_special_val,
  output logic [CNT_W-1:0] special_cnt,
  input  logic             flush
);

  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam logic [7:0] EXP_HALF = 8'd126;
  localparam int CLS_NAN  = 2;
  localparam int CLS_INF  = 1;
  localparam int CLS_ZERO = 0;

  // Class bits {nan, inf, zero}; exponent 0 counts as zero (DAZ).
  function automatic logic [2:0] classify(input logic [31:0] x);
    logic exp_max;
    logic man_nz;
    exp_max = (x[30:23] == EXP_MAX);
    man_nz  = |x[22:0];
    return {exp_max && man_nz, exp_max && !man_nz, x[30:23] == 8'd0};
  endfunction

  // Returns {special, value}; branch order sets the priority.
  function automatic logic [32:0] resolve(input logic [2:0] ca, input logic [2:0] cb,
                                          input logic sign);
    if (ca[CLS_NAN] || cb[CLS_NAN] || (ca[CLS_ZERO] && cb[CLS_ZERO]) ||
        (ca[CLS_INF] && cb[CLS_INF]))
      return {1'b1, QNAN};
    else if (ca[CLS_INF] || (cb[CLS_ZERO] && !ca[CLS_ZERO]))
      return {1'b1, sign, EXP_MAX, 23'h0};
    else if (ca[CLS_ZERO] || cb[CLS_INF])
      return {1'b1, sign, 31'h0};
    else
      return 33'h0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic        vld_p1, vld_p2;
  logic [31:0] a_p1, b_p1;
  logic [2:0]  cls_a_p1, cls_b_p1;
  logic        sign_p1;
  logic [31:0] a_p2, d_p2, special_val_p2;
  logic [7:0]  exp_b_p2;
  logic        sign_p2, special_p2;
  logic        ld_p2;
  logic [32:0] res_p1;

  // Stage 2 takes a new op when empty or draining; stage 1 likewise, which
  // makes in_ready combinational from out_ready.
  assign ld_p2    = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || ld_p2;
  assign res_p1   = resolve(cls_a_p1, cls_b_p1, sign_p1);

  // ---- stage 1: classify ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      a_p1     <= '0;
      b_p1     <= '0;
      cls_a_p1 <= '0;
      cls_b_p1 <= '0;
      sign_p1  <= 1'b0;
    end else begin
      if (flush)
        vld_p1 <= 1'b0;
      else if (in_ready)
        vld_p1 <= in_valid;
      if (in_valid && in_ready) begin
        a_p1     <= in_a;
        b_p1     <= in_b;
        cls_a_p1 <= classify(in_a);
        cls_b_p1 <= classify(in_b);
        sign_p1  <= in_a[31] ^ in_b[31];
      end
    end
  end

  // ---- stage 2: resolve ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2         <= 1'b0;
      a_p2           <= '0;
      d_p2           <= '0;
      exp_b_p2       <= '0;
      sign_p2        <= 1'b0;
      special_p2     <= 1'b0;
      special_val_p2 <= '0;
    end else begin
      if (flush)
        vld_p2 <= 1'b0;
      else if (ld_p2)
        vld_p2 <= vld_p1;
      if (vld_p1 && ld_p2) begin
        a_p2           <= cls_a_p1[CLS_ZERO] ? {a_p1[31], 31'h0} : a_p1;
        d_p2           <= {1'b0, EXP_HALF, b_p1[22:0]};
        exp_b_p2       <= b_p1[30:23];
        sign_p2        <= sign_p1;
        special_p2     <= res_p1[32];
        special_val_p2 <= res_p1[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      special_cnt <= '0;
    else if (vld_p2 && out_ready && special_p2)
      special_cnt <= sat_inc(special_cnt);
  end

  assign out_valid       = vld_p2;
  assign out_a           = a_p2;
  assign out_d           = d_p2;
  assign out_exp_b       = exp_b_p2;
  assign out_sign        = sign_p2;
  assign out_special     = special_p2;
  assign out_special_val = special_val_p2;

endmodule

// File: doc/fp_div_prep.md
Name: fp_div_prep

Overview:
- Pipelined operand-preparation stage directly upstream of the combinational Newton-Raphson divider.
- Accepts raw IEEE-754 single-precision dividend/divisor pairs over a valid/ready handshake and classifies special operands.
- Produces the divisor mantissa rescaled into [0.5,1) (exponent forced to 126), plus the sign, exponent and special-case result the divider core needs.
- Two register stages; full throughput of one operation per cycle; supports backpressure.

Parameters:
- CNT_W, 16, width of the saturating special-case event counter.
- QNAN, 32'h7FC00000, canonical quiet NaN emitted for invalid operations.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept operand pair this cycle
- in_a  input  32  dividend, IEEE-754 single
- in_b  input  32  divisor, IEEE-754 single
- out_valid  output  1  prepared operands valid
- out_ready  input  1  downstream divider accepts this cycle
- out_a  output  32  dividend passthrough (subnormal flushed to signed zero)
- out_d  output  32  {1'b0, 8'd126, in_b[22:0]}, divisor scaled into [0.5,1)
- out_exp_b  output  8  original biased divisor exponent
- out_sign  output  1  in_a[31] ^ in_b[31]
- out_special  output  1  result fully determined; downstream must bypass the divider
- out_special_val  output  32  final quotient when out_special=1, else 0
- special_cnt  output  CNT_W  saturating count of special ops delivered
- flush  input  1  synchronous clear of both stages

Behaviour:
- Reset (rst_n=0, asynchronous): both stage valids=0, all data registers=0, special_cnt=0. Outputs: out_valid=0, all data outputs=0, in_ready=1 after release.
- Handshake: a transfer occurs when valid&&ready on a clock edge. Stage k loads when its valid=0 or stage k+1 accepts it this cycle. in_ready = !v1 || !v2 || out_ready (combinational from out_ready is allowed).
- Latency: 2 cycles from input accept to out_valid, with no stall. Throughput: 1 per cycle.
- Once out_valid=1, out_* must hold stable until out_ready=1. Ordering is preserved; no drops, no duplicates.
- Stage 1 (classify): per operand, NaN = exp 255 and man≠0; Inf = exp 255 and man=0; Zero = exp 0 (subnormals are treated as zero, DAZ). Registers the class bits, sign, and both operands.
- Stage 2 (resolve), in priority order:
  - a or b NaN, 0/0, or Inf/Inf -> special=1, val=QNAN.
  - a Inf, or b Zero with a nonzero -> special=1, val={sign,8'hFF,23'h0}.
  - a Zero, or b Inf -> special=1, val={sign,31'h0}.
  - otherwise special=0, val=0.
- Stage 2 outputs: out_d and out_exp_b are computed from the original b. If a is subnormal, out_a={a[31],31'h0}.
- special_cnt increments on each output transfer with out_special=1 and saturates at all-ones.
- flush=1: both valids clear on the next edge, and any same-cycle input transfer is discarded. special_cnt is not affected. in_ready during flush is driven as normal.
- Reset mid-operation: in-flight ops are lost; no partial output ever appears.
- Simultaneous input accept and output drain when the pipe is full is legal: occupancy stays at 2.

Test Plan:
- a=0x40C00000 (6.0), b=0x40400000 (3.0), out_ready=1 -> 2 cycles later out_valid=1, out_d=0x3F400000, out_exp_b=0x80, out_sign=0, out_special=0.
- a=0x3F800000, b=0x00000000 -> out_special=1, out_special_val=0x7F800000, special_cnt increments 0->1. With b=0x80000000 -> val=0xFF800000.
- a=0, b=0 -> val=0x7FC00000. a=0x7F800000, b=0xFF800000 -> val=0x7FC00000. a=0x7FC00001, b=1.0 -> val=0x7FC00000.
- a=0xC0000000 (-2.0), b=0x7F800000 -> special=1, val=0x80000000. Subnormal a=0x00000001, b=1.0 -> val=0x00000000.
- Backpressure: out_ready=0 while streaming 4 ops on consecutive cycles -> exactly 2 accepted, then in_ready=0. Outputs hold stable. Release out_ready -> ops emerge in order, one per cycle, none lost.
- Assert rst_n=0 mid-stream with 2 ops in flight -> out_valid=0 immediately and special_cnt=0. Separately: flush with the pipe full -> out_valid=0 next cycle.
